// File: rtl/fifo_burst_reader.sv
// Burst reader for the read side of the data repeater FIFO: issues latency-tracked
// reads, parks returned words in a small skid buffer and frames them with a last flag.
module fifo_burst_reader #(
    parameter int DW         = 32,
    parameter int LEN_W      = 16,
    parameter int RD_LAT     = 1,
    parameter int SKID_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] burst_len_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             fifo_rd_o,
    input  logic [DW-1:0]    fifo_rd_dat_i,
    input  logic             fifo_rd_dat_valid_i,
    output logic [DW-1:0]    out_dat_o,
    output logic             out_valid_o,
    output logic             out_last_o,
    input  logic             out_ready_i
);

    localparam int AW = $clog2(SKID_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;

    state_t            state_reg, state_next;
    logic [LEN_W-1:0]  len_reg, received_reg, sent_reg;
    logic              abort_reg;
    logic [RD_LAT-1:0] pipe_reg, pipe_next;
    logic [PW-1:0]     head_reg, tail_reg;
    logic [DW-1:0]     mem_reg [SKID_DEPTH];

    logic              rd_req, push, pop, busy, drain_done, abort_active;
    logic [CW-1:0]     inflight;
    logic [PW-1:0]     skid_count;
    logic [LEN_W:0]    need_sum;
    logic [PW:0]       occ_sum;

    // Oldest request sits in the top bit; it is the only slot a return may belong to.
    generate
        if (RD_LAT == 1) begin : g_pipe_one
            assign pipe_next = rd_req;
        end else begin : g_pipe_many
            assign pipe_next = {pipe_reg[RD_LAT-2:0], rd_req};
        end
    endgenerate

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(pipe_reg[i]);
        end
    end

    assign busy        = (state_reg == ST_READ) || (state_reg == ST_DRAIN);
    assign skid_count  = tail_reg - head_reg;
    assign push        = fifo_rd_dat_valid_i && pipe_reg[RD_LAT-1] && busy;
    assign out_valid_o = (skid_count != '0);
    assign pop         = out_valid_o && out_ready_i;
    assign need_sum    = {1'b0, received_reg} + (LEN_W+1)'(inflight);
    assign occ_sum     = {1'b0, skid_count} + (PW+1)'(inflight);
    // A push implies inflight > 0, so this already covers "nothing arriving this cycle".
    assign drain_done  = (inflight == '0) && (skid_count == PW'(pop));
    assign abort_active = abort_reg || ((state_reg == ST_READ) && abort_i);

    always_comb begin
        state_next = state_reg;
        rd_req     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_i) state_next = ST_READ;
            end
            ST_READ: begin
                rd_req = (need_sum < {1'b0, len_reg}) &&
                         (occ_sum < (PW+1)'(SKID_DEPTH)) && !abort_i && !abort_reg;
                if ((received_reg == len_reg) || abort_i || (abort_reg && (inflight == '0)))
                    state_next = drain_done ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_done) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg    <= ST_IDLE;
            len_reg      <= '0;
            received_reg <= '0;
            sent_reg     <= '0;
            abort_reg    <= 1'b0;
            pipe_reg     <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) mem_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            pipe_reg  <= pipe_next;
            if ((state_reg == ST_IDLE) && start_i) begin
                len_reg      <= (burst_len_i == '0) ? LEN_W'(1) : burst_len_i;
                received_reg <= '0;
                sent_reg     <= '0;
                abort_reg    <= 1'b0;
            end else begin
                if (push) received_reg <= received_reg + LEN_W'(1);
                if (pop)  sent_reg     <= sent_reg + LEN_W'(1);
                if ((state_reg == ST_READ) && abort_i) abort_reg <= 1'b1;
            end
            if (push) begin
                mem_reg[tail_reg[AW-1:0]] <= fifo_rd_dat_i;
                tail_reg <= tail_reg + PW'(1);
            end
            if (pop) head_reg <= head_reg + PW'(1);
        end
    end

    assign out_dat_o  = out_valid_o ? mem_reg[head_reg[AW-1:0]] : '0;
    // After an abort the final word is the last one buffered with nothing left in flight.
    assign out_last_o = out_valid_o &&
                        ((sent_reg == len_reg - LEN_W'(1)) ||
                         (abort_active && (skid_count == PW'(1)) && (inflight == '0)));
    assign busy_o     = busy;
    assign done_o     = (state_reg == ST_DONE);
    assign fifo_rd_o  = rd_req;

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Single-clock reader that drains the read side of the data repeater FIFO and forwards words to a downstream bus consumer.
- Consumer interface is a valid/ready handshake with burst framing (last flag on the final word).
- Runs in the read-clock domain.
- Tracks read requests that are still in flight against a fixed FIFO read latency, and buffers returned words in a small skid buffer, so no word is ever dropped under downstream backpressure.

Parameters:
- DW, 32, data width.
- LEN_W, 16, width of the burst-length command.
- RD_LAT, 1, cycles from a fifo_rd_o pulse to its fifo_rd_dat_valid_i (1..4).
- SKID_DEPTH, 4, skid buffer entries (power of 2, must be >= RD_LAT+1).

Ports:
- clk_i  in  1  clock (FIFO read clock).
- reset_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; starts a burst; ignored while busy_o=1.
- burst_len_i  in  LEN_W  number of words in the burst, sampled on start_i; 0 is treated as 1.
- abort_i  in  1  stop issuing reads; finish the words already in flight.
- busy_o  out  1  burst in progress.
- done_o  out  1  one-cycle pulse when a burst completes or an abort completes.
- fifo_rd_o  out  1  FIFO read request.
- fifo_rd_dat_i  in  DW  FIFO read data.
- fifo_rd_dat_valid_i  in  1  FIFO read data valid.
- out_dat_o  out  DW  downstream data.
- out_valid_o  out  1  downstream valid.
- out_last_o  out  1  final word of the burst (qualified by out_valid_o).
- out_ready_i  in  1  downstream ready.

Behaviour:
- Reset values: busy_o=0, done_o=0, fifo_rd_o=0, out_valid_o=0, out_last_o=0, out_dat_o=0. All counters, the skid buffer and the in-flight pipe are cleared.
- FIFO contract:
  - Each fifo_rd_o=1 cycle returns exactly one fifo_rd_dat_valid_i pulse exactly RD_LAT cycles later, or nothing if the FIFO was empty.
  - In-flight reads are tracked in an RD_LAT-bit shift register; inflight = popcount of that register.
- States:
  - IDLE: waiting for a command.
    - start_i=1: latch len = max(burst_len_i,1), clear issued/received/sent counters, go to READ. busy_o=1 from the next cycle.
  - READ: issuing reads.
    - fifo_rd_o = (issued_ok < len) && (skid_count + inflight < SKID_DEPTH) && !abort.
    - issued_ok increments on each valid return, not on each request; an empty-FIFO miss does not consume length.
    - Go to DRAIN when received == len, or abort_i=1, or (abort latched and inflight reaches 0).
  - DRAIN: fifo_rd_o=0; wait until inflight == 0 and the skid buffer is empty, then go to DONE.
  - DONE: done_o=1 for one cycle, busy_o=0, then IDLE.
- Over-issue guard:
  - Requests may exceed the words still needed only by words already in flight.
  - The gating condition is (received + inflight) < len; the last words never over-read the FIFO.
- Skid buffer:
  - Circular buffer with head/tail pointers of log2(SKID_DEPTH)+1 bits; wrap handled by the MSB.
  - Every fifo_rd_dat_valid_i word is pushed unconditionally. Overflow is impossible by construction; the bench asserts it never occurs.
  - Output is registered: out_valid_o = skid non-empty. A word pops on out_valid_o && out_ready_i.
- Downstream handshake:
  - out_dat_o and out_last_o are held stable while out_valid_o=1 and out_ready_i=0.
  - out_last_o=1 on the word where sent == len-1, or on the last buffered word of an aborted burst.
- Simultaneous events:
  - A push and a pop in the same cycle leave the count unchanged.
  - start_i arriving in the same cycle as done_o is ignored; the new command is accepted only in IDLE.
- abort_i in IDLE: no effect.
- Reset mid-burst: everything returns immediately to reset values; in-flight FIFO data arriving after reset is discarded.

Test Plan:
- Start with len=10, FIFO preloaded with 1..10, out_ready_i=1 -> out_dat_o = 1..10 on consecutive cycles after the start latency; out_last_o with word 10; exactly 10 fifo_rd_o pulses; done_o one cycle after the last pop.
- Start with len=5, FIFO holding 2 words; 3 more words written 50 ns later -> fifo_rd_o retries while empty; output 1..5 with last on 5; no extra reads after the 5th valid return.
- Start with len=8, out_ready_i held low for 20 cycles -> fifo_rd_o stops after SKID_DEPTH words are buffered or in flight; out_dat_o stays stable; on release, 1..8 in order with no loss or duplication.
- Start with len=20, abort_i after 6 words returned, RD_LAT=2 -> no reads issued after the abort; in-flight words delivered; out_last_o on the final delivered word; done_o pulses; busy_o=0.
- burst_len_i=0 -> exactly one word delivered with out_last_o=1.
- reset_n_i asserted mid-burst with a word in flight -> all outputs 0 asynchronously; the late valid is ignored; a new start after release behaves normally.
